// File: rtl/pipe_regs_vr.sv
// pipe_regs_vr: DEPTH-stage pipeline register with valid/ready flow control,
// per-stage flush and a registered occupancy count. Stage 0 faces the input,
// stage DEPTH-1 drives the output.
module pipe_regs_vr #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic [DEPTH-1:0]           flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] ev;
    logic [DEPTH-1:0] src_v;
    logic [DEPTH-1:0] mv_in;
    logic [DEPTH-1:0] mv_out;
    logic [DEPTH:0]   r;
    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] d_nxt [DEPTH];
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [CW-1:0]    count_nxt;

    // Ready ripples back from the output; a stage is ready when empty,
    // flushed, or its successor is ready. Then the per-stage moves and next state.
    always_comb begin
        r        = '0;
        r[DEPTH] = out_ready;
        for (int k = DEPTH-1; k >= 0; k--) begin
            r[k] = ~v[k] | flush[k] | r[k+1];
        end

        ev       = v & ~flush;
        src_v    = '0;
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = ev[k-1];
            src_d[k] = d[k-1];
        end

        mv_in  = src_v & r[DEPTH-1:0];
        mv_out = ev & r[DEPTH:1];

        v_nxt     = v;
        count_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            d_nxt[k] = d[k];
            // A flushed stage drops even an item arriving this cycle; the
            // upstream handshake still completes.
            if (flush[k])
                v_nxt[k] = 1'b0;
            else if (mv_in[k])
                v_nxt[k] = 1'b1;
            else if (mv_out[k])
                v_nxt[k] = 1'b0;

            if (flush[k] && CLEAR_DATA)
                d_nxt[k] = '0;
            else if (mv_in[k])
                d_nxt[k] = src_d[k];

            count_nxt = count_nxt + CW'(v_nxt[k]);
        end
    end

    // Stage registers and occupancy count; reset empties and zeroes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            v     <= '0;
            count <= '0;
            for (int k = 0; k < DEPTH; k++) d[k] <= '0;
        end else begin
            v     <= v_nxt;
            count <= count_nxt;
            for (int k = 0; k < DEPTH; k++) d[k] <= d_nxt[k];
        end
    end

    assign in_ready  = r[0];
    assign out_valid = ev[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule

// File: doc/pipe_regs_vr.md
# pipe_regs_vr

Parametrised multi-stage pipeline register with valid/ready flow control, per-stage flush and occupancy count. It is the next generation of the team's single-stage clearable flip-flop. It replaces hand-chained enable/clear registers between processor pipeline stages: bubbles collapse, stalls propagate backwards, and any subset of stages can be killed in one cycle (e.g. on branch mispredict).

## Interface
- WIDTH, 32, payload bits per stage
- DEPTH, 2, number of register stages (≥1); stage 0 is input side, stage DEPTH-1 drives the output
- CLEAR_DATA, 1, when 1 flush also zeroes the stage's data register; when 0 data is left unchanged (only valid clears)

- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high; clock clk
- in_valid  in  1  upstream presents in_data
- in_ready  out  1  block accepts in_data this cycle (combinational)
- in_data  in  WIDTH  payload
- out_valid  out  1  stage DEPTH-1 holds live data (combinational, flush-masked)
- out_ready  in  1  downstream accepts out_data
- out_data  out  WIDTH  data register of stage DEPTH-1
- flush  in  DEPTH  bit k kills stage k this cycle
- count  out  $clog2(DEPTH+1)  registered number of valid stages

## Operation
- Per stage k: registers v[k] (valid) and d[k] (WIDTH).
- Effective valid: ev[k] = v[k] & ~flush[k].
- Ready chain: r[DEPTH] = out_ready; r[k] = ~v[k] | flush[k] | r[k+1]. in_ready = r[0]; out_valid = ev[DEPTH-1]; out_data = d[DEPTH-1].
- Source valid into stage k: s[0] = in_valid; s[k] = ev[k-1] for k≥1.
- Move into k: s[k] & r[k]. Move out of k: ev[k] & r[k+1].
- Next v[k]:
  - flush[k] → 0, including any item moving in that cycle, which is dropped; upstream still sees the handshake complete.
  - else move in → 1.
  - else move out → 0.
  - else hold.
- Next d[k]:
  - flush[k] & CLEAR_DATA → 0.
  - else move in → d_src (in_data or d[k-1]).
  - else hold. Data is never modified without a move-in or a flush.
- Bubble collapse: an empty or flushed stage accepts even while downstream stalls.
- Ordering: items leave in arrival order; no duplication; no loss except by flush.
- count = popcount of next v[] registered; it always equals popcount(v[]) of the current cycle.
- Reset: all v = 0, all d = 0, count = 0. Hence out_valid = 0 and in_ready = 1 during and after reset. Reset overrides flush and handshakes; mid-stream reset discards all contents.

## Timing
- Latency: an item accepted at edge N appears at out_valid after edge N+DEPTH-1 if never stalled, i.e. DEPTH register hops counting the capture.
- Throughput: one item per cycle with out_ready held high.
- Combinational paths: out_ready→in_ready (ripple through DEPTH stages) and flush→in_ready/out_valid. No path from in_valid to in_ready.
- Full (all v=1, out_ready=0, flush=0): in_ready=0 and contents hold. With out_ready rising while full, in_ready=1 in the same cycle (no dead cycle).
- Simultaneous flush[k] and upstream move into k: the item is consumed upstream and discarded; v[k]=0 next cycle.
- Simultaneous flush[DEPTH-1] and out_ready=1: out_valid=0, so no transfer occurs downstream.
- DEPTH=1 degenerates to a single valid/ready register with clear; in_ready = ~v | flush | out_ready.

## Test plan
- Reset/fill: WIDTH=32, DEPTH=3. Assert reset 2 cycles → out_valid=0, count=0, in_ready=1. Push 0xA1,0xA2,0xA3 back-to-back with out_ready=1 → 0xA1 at out on the 3rd cycle after the first accept, then 0xA2, 0xA3 on consecutive cycles.
- Stall/full: out_ready=0, push 4 items → first 3 accepted, count=3, in_ready=0 on the 4th. Raise out_ready → same-cycle in_ready=1, order preserved, no loss.
- Bubble collapse: v=1,0,1 (stage0,1,2), out_ready=0 → stage0 advances into stage1 and in_ready=1; count stays 2 plus any new accept.
- Flush: stages full with 0x11,0x22,0x33, flush=3'b011 → next cycle v=0,0,1 and stage0/1 data = 0 (CLEAR_DATA=1); with CLEAR_DATA=0, data held; count=1.
- Flush vs input: flush[0]=1 with in_valid=1 (in_data 0x55) → in_ready=1 and 0x55 never appears at the output.
- Reset mid-stream: 2 items in flight, reset for 1 cycle → next cycle count=0, out_valid=0, out_data=0.
